// File: rtl/maze_irs_link.sv
// MAZE mesh inter-node link slice: DEPTH-stage X/Y register pipes
// with power-gate kill of packets targeting the gated node.
module maze_irs_link #(
  parameter int DEPTH  = 2,
  parameter int ID_W   = 6,
  parameter int QOS_W  = 1,
  parameter int TYPE_W = 2,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pg_en,
  input  logic [ID_W-1:0]   pg_node,
  input  logic              x_vld_i,
  input  logic [QOS_W-1:0]  x_qos_i,
  input  logic [TYPE_W-1:0] x_type_i,
  input  logic [ID_W-1:0]   x_src_i,
  input  logic [ID_W-1:0]   x_tgt_i,
  input  logic [DATA_W-1:0] x_data_i,
  input  logic              y_vld_i,
  input  logic [QOS_W-1:0]  y_qos_i,
  input  logic [TYPE_W-1:0] y_type_i,
  input  logic [ID_W-1:0]   y_src_i,
  input  logic [ID_W-1:0]   y_tgt_i,
  input  logic [DATA_W-1:0] y_data_i,
  output logic              x_vld_o,
  output logic [QOS_W-1:0]  x_qos_o,
  output logic [TYPE_W-1:0] x_type_o,
  output logic [ID_W-1:0]   x_src_o,
  output logic [ID_W-1:0]   x_tgt_o,
  output logic [DATA_W-1:0] x_data_o,
  output logic [3:0]        x_occ_o,
  output logic              y_vld_o,
  output logic [QOS_W-1:0]  y_qos_o,
  output logic [TYPE_W-1:0] y_type_o,
  output logic [ID_W-1:0]   y_src_o,
  output logic [ID_W-1:0]   y_tgt_o,
  output logic [DATA_W-1:0] y_data_o,
  output logic [3:0]        y_occ_o,
  output logic [15:0]       drop_cnt_o
);

  typedef struct packed {
    logic              vld;
    logic [QOS_W-1:0]  qos;
    logic [TYPE_W-1:0] ptype;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
    logic [DATA_W-1:0] data;
  } pkt_t;

  pkt_t        in_p [2];
  pkt_t        st_q [2][DEPTH];
  pkt_t        st_d [2][DEPTH];
  logic [4:0]  kill_sum;
  logic [16:0] cnt_sum;
  logic [15:0] drop_q;
  logic [3:0]  occ [2];
  logic        last_kill [2];

  function automatic logic kill_f(
    input pkt_t           p,
    input logic           en,
    input logic [ID_W-1:0] node
  );
    return en & p.vld & (p.tgt == node);
  endfunction

  assign in_p[0] = {x_vld_i, x_qos_i, x_type_i,
                    x_src_i, x_tgt_i, x_data_i};
  assign in_p[1] = {y_vld_i, y_qos_i, y_type_i,
                    y_src_i, y_tgt_i, y_data_i};

  // payload always shifts; only vld is masked by the kill
  always_comb begin
    kill_sum = '0;
    for (int c = 0; c < 2; c++) begin
      st_d[c][0]     = in_p[c];
      st_d[c][0].vld = in_p[c].vld &
                       ~kill_f(in_p[c], pg_en, pg_node);
      kill_sum = kill_sum +
                 5'(kill_f(in_p[c], pg_en, pg_node));
      for (int k = 1; k < DEPTH; k++) begin
        st_d[c][k]     = st_q[c][k-1];
        st_d[c][k].vld = st_q[c][k-1].vld &
                         ~kill_f(st_q[c][k-1], pg_en, pg_node);
      end
      for (int k = 0; k < DEPTH; k++) begin
        kill_sum = kill_sum +
                   5'(kill_f(st_q[c][k], pg_en, pg_node));
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      occ[c] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        occ[c] = occ[c] + 4'(st_q[c][k].vld);
      end
      last_kill[c] = kill_f(st_q[c][DEPTH-1], pg_en, pg_node);
    end
  end

  assign cnt_sum = {1'b0, drop_q} + 17'(kill_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          st_q[c][k] <= '0;
        end
      end
      drop_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          st_q[c][k] <= st_d[c][k];
        end
      end
      drop_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign x_vld_o  = st_q[0][DEPTH-1].vld & ~last_kill[0];
  assign x_qos_o  = st_q[0][DEPTH-1].qos;
  assign x_type_o = st_q[0][DEPTH-1].ptype;
  assign x_src_o  = st_q[0][DEPTH-1].src;
  assign x_tgt_o  = st_q[0][DEPTH-1].tgt;
  assign x_data_o = st_q[0][DEPTH-1].data;
  assign x_occ_o  = occ[0];

  assign y_vld_o  = st_q[1][DEPTH-1].vld & ~last_kill[1];
  assign y_qos_o  = st_q[1][DEPTH-1].qos;
  assign y_type_o = st_q[1][DEPTH-1].ptype;
  assign y_src_o  = st_q[1][DEPTH-1].src;
  assign y_tgt_o  = st_q[1][DEPTH-1].tgt;
  assign y_data_o = st_q[1][DEPTH-1].data;
  assign y_occ_o  = occ[1];

  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_maze_irs_link.sv
// Directed bench for maze_irs_link (DEPTH=2): delay, stream,
// power-gate kills, saturation and asynchronous reset.
module tb_maze_irs_link;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pg_en = 1'b0;
  logic [5:0]   pg_node = '0;
  logic         x_vld_i = 1'b0, y_vld_i = 1'b0;
  logic [0:0]   x_qos_i = '0, y_qos_i = '0;
  logic [1:0]   x_type_i = '0, y_type_i = '0;
  logic [5:0]   x_src_i = '0, y_src_i = '0;
  logic [5:0]   x_tgt_i = '0, y_tgt_i = '0;
  logic [127:0] x_data_i = '0, y_data_i = '0;
  logic         x_vld_o, y_vld_o;
  logic [0:0]   x_qos_o, y_qos_o;
  logic [1:0]   x_type_o, y_type_o;
  logic [5:0]   x_src_o, y_src_o;
  logic [5:0]   x_tgt_o, y_tgt_o;
  logic [127:0] x_data_o, y_data_o;
  logic [3:0]   x_occ_o, y_occ_o;
  logic [15:0]  drop_cnt_o;

  int checks = 0;
  int failures = 0;
  int x_seen;
  int y_seen;

  maze_irs_link #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pg_en(pg_en), .pg_node(pg_node),
    .x_vld_i(x_vld_i), .x_qos_i(x_qos_i), .x_type_i(x_type_i),
    .x_src_i(x_src_i), .x_tgt_i(x_tgt_i), .x_data_i(x_data_i),
    .y_vld_i(y_vld_i), .y_qos_i(y_qos_i), .y_type_i(y_type_i),
    .y_src_i(y_src_i), .y_tgt_i(y_tgt_i), .y_data_i(y_data_i),
    .x_vld_o(x_vld_o), .x_qos_o(x_qos_o), .x_type_o(x_type_o),
    .x_src_o(x_src_o), .x_tgt_o(x_tgt_o), .x_data_o(x_data_o),
    .x_occ_o(x_occ_o),
    .y_vld_o(y_vld_o), .y_qos_o(y_qos_o), .y_type_o(y_type_o),
    .y_src_o(y_src_o), .y_tgt_o(y_tgt_o), .y_data_o(y_data_o),
    .y_occ_o(y_occ_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    x_vld_i = 1'b0; x_qos_i = '0; x_type_i = '0;
    x_src_i = '0; x_tgt_i = '0; x_data_i = '0;
    y_vld_i = 1'b0; y_qos_i = '0; y_type_i = '0;
    y_src_i = '0; y_tgt_i = '0; y_data_i = '0;
  endtask

  initial begin
    idle();
    #12;
    chk("rst_x_vld", 128'(x_vld_o), 128'd0);
    chk("rst_x_data", x_data_o, 128'd0);
    chk("rst_y_tgt", 128'(y_tgt_o), 128'd0);
    chk("rst_occ", 128'({x_occ_o, y_occ_o}), 128'd0);
    chk("rst_drop", 128'(drop_cnt_o), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single packet, pure delay
    x_vld_i = 1'b1; x_tgt_i = 6'h09; x_data_i = 128'hA5;
    x_qos_i = 1'b1; x_type_i = 2'd2; x_src_i = 6'h21;
    tick();
    idle();
    chk("p1_occ0", 128'(x_occ_o), 128'd1);
    chk("p1_vld0", 128'(x_vld_o), 128'd0);
    tick();
    chk("p1_vld1", 128'(x_vld_o), 128'd1);
    chk("p1_data", x_data_o, 128'hA5);
    chk("p1_tgt", 128'(x_tgt_o), 128'h09);
    chk("p1_fields", 128'({x_qos_o, x_type_o, x_src_o}),
        128'({1'b1, 2'd2, 6'h21}));
    chk("p1_occ1", 128'(x_occ_o), 128'd1);
    chk("p1_y_idle", 128'(y_vld_o), 128'd0);
    tick();
    chk("p1_vld2", 128'(x_vld_o), 128'd0);
    chk("p1_occ2", 128'(x_occ_o), 128'd0);
    chk("p1_drop", 128'(drop_cnt_o), 128'd0);

    // back-to-back stream on both channels
    x_seen = 0;
    y_seen = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        x_vld_i = 1'b1; x_tgt_i = 6'(i + 1);
        x_data_i = 128'(i) | (128'hC0DE << 64);
        y_vld_i = 1'b1; y_tgt_i = 6'(i + 32);
        y_data_i = 128'(i + 100);
      end else begin
        idle();
      end
      tick();
      if (x_vld_o) x_seen++;
      if (y_vld_o) y_seen++;
      if (i >= 1) begin
        chk("st_x_vld", 128'(x_vld_o), 128'd1);
        chk("st_x_data", x_data_o,
            128'(i - 1) | (128'hC0DE << 64));
        chk("st_y_data", y_data_o, 128'(i + 99));
        chk("st_y_tgt", 128'(y_tgt_o), 128'(i + 31));
      end
      if (i == 16) break;
    end
    idle();
    tick();
    chk("st_x_count", 128'(x_seen), 128'd16);
    chk("st_y_count", 128'(y_seen), 128'd16);
    chk("st_drain", 128'({x_vld_o, y_vld_o}), 128'd0);
    chk("st_drop", 128'(drop_cnt_o), 128'd0);

    // kill at input, neighbour delivered
    pg_en = 1'b1; pg_node = 6'h12;
    x_vld_i = 1'b1; x_tgt_i = 6'h12; x_data_i = 128'h77;
    tick();
    chk("k_drop1", 128'(drop_cnt_o), 128'd1);
    chk("k_occ", 128'(x_occ_o), 128'd0);
    x_tgt_i = 6'h13; x_data_i = 128'h88;
    tick();
    idle();
    chk("k_occ13", 128'(x_occ_o), 128'd1);
    chk("k_vld_early", 128'(x_vld_o), 128'd0);
    tick();
    chk("k_vld13", 128'(x_vld_o), 128'd1);
    chk("k_data13", x_data_o, 128'h88);
    chk("k_drop_hold", 128'(drop_cnt_o), 128'd1);

    // src equal to the gated node does not kill
    x_vld_i = 1'b1; x_src_i = 6'h12; x_tgt_i = 6'h05;
    x_data_i = 128'h99;
    tick();
    idle();
    tick();
    chk("src_vld", 128'(x_vld_o), 128'd1);
    chk("src_data", x_data_o, 128'h99);
    chk("src_drop", 128'(drop_cnt_o), 128'd1);

    // pg_en rises with match in last stage
    pg_en = 1'b0;
    tick();
    x_vld_i = 1'b1; x_tgt_i = 6'h12; x_data_i = 128'h55;
    tick();
    idle();
    tick();
    chk("last_vld_off", 128'(x_vld_o), 128'd1);
    pg_en = 1'b1;
    #1;
    chk("last_gated", 128'(x_vld_o), 128'd0);
    chk("last_occ_raw", 128'(x_occ_o), 128'd1);
    tick();
    chk("last_drop", 128'(drop_cnt_o), 128'd2);
    chk("last_occ", 128'(x_occ_o), 128'd0);

    // dual-channel kill in one edge
    x_vld_i = 1'b1; x_tgt_i = 6'h12;
    y_vld_i = 1'b1; y_tgt_i = 6'h12;
    tick();
    chk("dual_drop", 128'(drop_cnt_o), 128'd4);
    for (int i = 0; i < 32765; i++) tick();
    chk("pre_sat", 128'(drop_cnt_o), 128'hFFFE);

    // three kills at FFFE: one in stage 0, two at inputs
    idle();
    pg_en = 1'b0;
    x_vld_i = 1'b1; x_tgt_i = 6'h12;
    tick();
    chk("sat_occ", 128'(x_occ_o), 128'd1);
    chk("sat_nokill", 128'(drop_cnt_o), 128'hFFFE);
    pg_en = 1'b1;
    y_vld_i = 1'b1; y_tgt_i = 6'h12;
    tick();
    idle();
    chk("sat_ffff", 128'(drop_cnt_o), 128'hFFFF);
    chk("sat_occ0", 128'({x_occ_o, y_occ_o}), 128'd0);
    x_vld_i = 1'b1; x_tgt_i = 6'h12;
    tick();
    idle();
    chk("sat_hold", 128'(drop_cnt_o), 128'hFFFF);

    // async reset with two packets in flight
    pg_en = 1'b0;
    x_vld_i = 1'b1; x_tgt_i = 6'h01; x_data_i = 128'h1;
    tick();
    x_tgt_i = 6'h02; x_data_i = 128'h2;
    tick();
    idle();
    chk("pre_rst_occ", 128'(x_occ_o), 128'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 128'(x_vld_o), 128'd0);
    chk("ar_data", x_data_o, 128'd0);
    chk("ar_tgt", 128'(x_tgt_o), 128'd0);
    chk("ar_occ", 128'(x_occ_o), 128'd0);
    chk("ar_drop", 128'(drop_cnt_o), 128'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_stale", 128'(x_vld_o), 128'd0);
    end
    chk("ar_drop_after", 128'(drop_cnt_o), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
